// File: rtl/sdram_frame_fetch.sv
// Streams one frame of 16-bit pixels from SDRAM into the display FIFO as fixed-length read bursts.
// Optional build macro FETCH_DBUF_EN: alternate frame base between BASE0 and BASE1 on each accepted frame start.
module sdram_frame_fetch #(
  parameter int                ADDR_W      = 22,
  parameter int                FIFO_AW     = 10,
  parameter int                BURST       = 8,
  parameter int                FRAME_WORDS = 307200,
  parameter logic [ADDR_W-1:0] BASE0       = 22'h000000,
  parameter logic [ADDR_W-1:0] BASE1       = 22'h080000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic [FIFO_AW-1:0] fifo_usedw,
  output logic               fifo_wrreq,
  output logic [15:0]        fifo_wrdata,
  output logic               fifo_aclr,
  output logic               sdr_rd_req,
  output logic [ADDR_W-1:0]  sdr_rd_addr,
  input  logic               sdr_rd_ack,
  input  logic               sdr_rd_valid,
  input  logic [15:0]        sdr_rd_data,
  output logic               frame_done
);

  typedef enum logic [2:0] {IDLE, CHECK, REQ, DATA, DONE, FLUSH} state_t;

  localparam int                 BW        = $clog2(BURST);
  localparam logic [FIFO_AW:0]   ROOM      = (FIFO_AW+1)'(2**FIFO_AW - 2*BURST);
  localparam logic [ADDR_W-1:0]  BURST_A   = ADDR_W'(BURST);
  localparam logic [ADDR_W-1:0]  FRAME_A   = ADDR_W'(FRAME_WORDS);
  localparam logic [BW-1:0]      LAST_BEAT = BW'(BURST-1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   offset_q, offset_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic                pend_q, pend_d;
  logic                req_q, req_d;
  logic                aclr_q, aclr_d;
  logic                wr_q, wr_d;
  logic [15:0]         wrdata_q, wrdata_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   base;
  logic                room;
  logic                restart;

  assign room    = {1'b0, fifo_usedw} <= ROOM;
  assign restart = frame_start && (state_q == IDLE || state_q == CHECK || state_q == DONE);

`ifdef FETCH_DBUF_EN
  // sel_q resets to 1 so the first accepted frame start selects BASE0.
  logic sel_q;
  logic accept;
  assign accept = restart ||
                  (frame_start && !pend_q && (state_q == REQ || state_q == DATA));
  assign base   = sel_q ? BASE1 : BASE0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         sel_q <= 1'b1;
    else if (accept) sel_q <= ~sel_q;
  end
`else
  localparam logic SEL_FIXED = 1'b0;
  assign base = SEL_FIXED ? BASE1 : BASE0;
`endif

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    addr_d   = addr_q;
    beat_d   = beat_q;
    pend_d   = pend_q;
    req_d    = req_q;
    wr_d     = 1'b0;
    wrdata_d = wrdata_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE, DONE: if (restart) state_d = FLUSH;
      CHECK: begin
        if (restart) begin
          state_d = FLUSH;
        end else if (room) begin
          req_d   = 1'b1;
          addr_d  = base + offset_q;
          state_d = REQ;
        end
      end
      REQ: begin
        if (frame_start) pend_d = 1'b1;
        if (sdr_rd_ack) begin
          req_d    = 1'b0;
          offset_d = offset_q + BURST_A;
          beat_d   = '0;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (frame_start) pend_d = 1'b1;
        // Words of a burst overtaken by a frame start still drain, but never reach the FIFO.
        if (sdr_rd_valid) begin
          beat_d = beat_q + BW'(1);
          if (!pend_q) begin
            wr_d     = 1'b1;
            wrdata_d = sdr_rd_data;
          end
          if (beat_q == LAST_BEAT) begin
            done_d = !pend_q && (offset_q == FRAME_A);
            if (pend_q || frame_start)   state_d = FLUSH;
            else if (offset_q == FRAME_A) state_d = DONE;
            else                          state_d = CHECK;
          end
        end
      end
      FLUSH:   state_d = CHECK;
      default: state_d = IDLE;
    endcase
    if (state_d == FLUSH) begin
      offset_d = '0;
      pend_d   = 1'b0;
    end
    aclr_d = (state_d == FLUSH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      offset_q <= '0;
      addr_q   <= BASE0;
      beat_q   <= '0;
      pend_q   <= 1'b0;
      req_q    <= 1'b0;
      aclr_q   <= 1'b0;
      wr_q     <= 1'b0;
      wrdata_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      addr_q   <= addr_d;
      beat_q   <= beat_d;
      pend_q   <= pend_d;
      req_q    <= req_d;
      aclr_q   <= aclr_d;
      wr_q     <= wr_d;
      wrdata_q <= wrdata_d;
      done_q   <= done_d;
    end
  end

  assign fifo_wrreq  = wr_q;
  assign fifo_wrdata = wrdata_q;
  assign fifo_aclr   = aclr_q;
  assign sdr_rd_req  = req_q;
  assign sdr_rd_addr = addr_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_sdram_frame_fetch.sv
// Directed bench for sdram_frame_fetch with a 64-word frame and 8-word bursts.
module tb_sdram_frame_fetch;

  localparam int          AW    = 22;
  localparam int          FAW   = 10;
  localparam int          BURST = 8;
  localparam int          FW    = 64;
  localparam logic [21:0] B0    = 22'h000000;
  localparam logic [21:0] B1    = 22'h080000;
`ifdef FETCH_DBUF_EN
  localparam logic [21:0] RESTART_BASE = B1;
  localparam logic [21:0] F2_BASE      = B1;
`else
  localparam logic [21:0] RESTART_BASE = B0;
  localparam logic [21:0] F2_BASE      = B0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           frame_start;
  logic [FAW-1:0] fifo_usedw;
  logic           fifo_wrreq;
  logic [15:0]    fifo_wrdata;
  logic           fifo_aclr;
  logic           sdr_rd_req;
  logic [AW-1:0]  sdr_rd_addr;
  logic           sdr_rd_ack;
  logic           sdr_rd_valid;
  logic [15:0]    sdr_rd_data;
  logic           frame_done;

  int checks = 0;
  int fails  = 0;
  logic [15:0] wq[$];
  int n_aclr, n_done, done_at, bad_done;

  sdram_frame_fetch #(
    .ADDR_W(AW), .FIFO_AW(FAW), .BURST(BURST), .FRAME_WORDS(FW), .BASE0(B0), .BASE1(B1)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .fifo_usedw(fifo_usedw),
    .fifo_wrreq(fifo_wrreq), .fifo_wrdata(fifo_wrdata), .fifo_aclr(fifo_aclr),
    .sdr_rd_req(sdr_rd_req), .sdr_rd_addr(sdr_rd_addr), .sdr_rd_ack(sdr_rd_ack),
    .sdr_rd_valid(sdr_rd_valid), .sdr_rd_data(sdr_rd_data), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_wrreq) wq.push_back(fifo_wrdata);
      if (fifo_aclr) n_aclr++;
      if (frame_done) begin
        n_done++;
        done_at = wq.size();
        if (!fifo_wrreq) bad_done++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    frame_start = 1'b0; fifo_usedw = '0; sdr_rd_ack = 1'b0;
    sdr_rd_valid = 1'b0; sdr_rd_data = '0;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    wq.delete();
    n_aclr = 0; n_done = 0; done_at = -1; bad_done = 0;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (sdr_rd_req) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++; fails++;
      $display("FAIL req_timeout sdr_rd_req never rose within 50 cycles");
    end
  endtask

  task automatic ack_and_feed(input logic [15:0] d0, input int nwords);
    sdr_rd_ack = 1'b1;
    @(negedge clk);
    sdr_rd_ack = 1'b0;
    for (int i = 0; i < nwords; i++) begin
      sdr_rd_valid = 1'b1;
      sdr_rd_data  = d0 + 16'(i);
      @(negedge clk);
    end
    sdr_rd_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (fifo_wrreq !== 1'b0) begin fails++; $display("FAIL rst_wrreq got %b want 0", fifo_wrreq); end
    checks++; if (fifo_wrdata !== 16'h0) begin fails++; $display("FAIL rst_wrdata got %h want 0000", fifo_wrdata); end
    checks++; if (fifo_aclr !== 1'b0) begin fails++; $display("FAIL rst_aclr got %b want 0", fifo_aclr); end
    checks++; if (sdr_rd_req !== 1'b0) begin fails++; $display("FAIL rst_req got %b want 0", sdr_rd_req); end
    checks++; if (sdr_rd_addr !== B0) begin fails++; $display("FAIL rst_addr got %h want %h", sdr_rd_addr, B0); end
    checks++; if (frame_done !== 1'b0) begin fails++; $display("FAIL rst_done got %b want 0", frame_done); end
  endtask

  task automatic test_full_frame();
    bit ok;
    logic [15:0] exp;
    bit seen;
    do_reset();
    pulse_fs();
    checks++; if (fifo_aclr !== 1'b1) begin fails++; $display("FAIL ff_aclr_hi got %b want 1", fifo_aclr); end
    checks++; if (sdr_rd_req !== 1'b0) begin fails++; $display("FAIL ff_req_during_aclr got %b want 0", sdr_rd_req); end
    cyc(1);
    checks++; if (fifo_aclr !== 1'b0) begin fails++; $display("FAIL ff_aclr_lo got %b want 0", fifo_aclr); end
    for (int b = 0; b < FW / BURST; b++) begin
      wait_req(ok);
      if (!ok) return;
      checks++;
      if (sdr_rd_addr !== B0 + 22'(b * BURST)) begin
        fails++; $display("FAIL ff_addr burst %0d got %h want %h", b, sdr_rd_addr, B0 + 22'(b * BURST));
      end
      ack_and_feed(16'h1000 + 16'(b * BURST), BURST);
    end
    cyc(3);
    checks++; if (wq.size() !== FW) begin fails++; $display("FAIL ff_wcount got %0d want %0d", wq.size(), FW); end
    for (int i = 0; i < FW && i < wq.size(); i++) begin
      exp = 16'h1000 + 16'(i);
      checks++; if (wq[i] !== exp) begin fails++; $display("FAIL ff_data[%0d] got %h want %h", i, wq[i], exp); end
    end
    checks++; if (n_done !== 1) begin fails++; $display("FAIL ff_done_count got %0d want 1", n_done); end
    checks++; if (done_at !== FW) begin fails++; $display("FAIL ff_done_pos got %0d want %0d", done_at, FW); end
    checks++; if (bad_done !== 0) begin fails++; $display("FAIL ff_done_no_write got %0d want 0", bad_done); end
    checks++; if (n_aclr !== 1) begin fails++; $display("FAIL ff_aclr_count got %0d want 1", n_aclr); end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin seen |= sdr_rd_req; @(negedge clk); end
    checks++; if (seen !== 1'b0) begin fails++; $display("FAIL ff_done_idle req seen %b want 0", seen); end
  endtask

  task automatic test_threshold_ackdelay();
    bit seen;
    do_reset();
    fifo_usedw = FAW'(2**FAW - 2*BURST + 1);
    pulse_fs();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin seen |= sdr_rd_req; @(negedge clk); end
    checks++; if (seen !== 1'b0) begin fails++; $display("FAIL thr_full req seen %b want 0", seen); end
    fifo_usedw = FAW'(2**FAW - 2*BURST);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++; if (sdr_rd_req !== 1'b1) begin fails++; $display("FAIL ackdly_req cyc %0d got %b want 1", i, sdr_rd_req); end
      checks++; if (sdr_rd_addr !== B0) begin fails++; $display("FAIL ackdly_addr cyc %0d got %h want %h", i, sdr_rd_addr, B0); end
      if (i == 4) sdr_rd_ack = 1'b1;
      @(negedge clk);
    end
    sdr_rd_ack = 1'b0;
    checks++; if (sdr_rd_req !== 1'b0) begin fails++; $display("FAIL ackdly_drop got %b want 0", sdr_rd_req); end
    for (int i = 0; i < BURST; i++) begin
      sdr_rd_valid = 1'b1; sdr_rd_data = 16'h5A00 + 16'(i);
      @(negedge clk);
    end
    sdr_rd_valid = 1'b0;
    cyc(2);
    checks++; if (wq.size() !== BURST) begin fails++; $display("FAIL thr_wcount got %0d want %0d", wq.size(), BURST); end
    if (wq.size() >= BURST) begin
      checks++; if (wq[BURST-1] !== 16'h5A07) begin fails++; $display("FAIL thr_lastdata got %h want 5a07", wq[BURST-1]); end
    end
  endtask

  task automatic test_restart();
    bit ok;
    do_reset();
    pulse_fs();
    cyc(1);
    n_aclr = 0;
    for (int b = 0; b < 3; b++) begin
      wait_req(ok);
      if (!ok) return;
      ack_and_feed(16'h2000 + 16'(b * BURST), BURST);
    end
    wait_req(ok);
    if (!ok) return;
    checks++; if (sdr_rd_addr !== B0 + 22'd24) begin fails++; $display("FAIL rs_addr4 got %h want %h", sdr_rd_addr, B0 + 22'd24); end
    sdr_rd_ack = 1'b1;
    @(negedge clk);
    sdr_rd_ack = 1'b0;
    for (int i = 0; i < BURST; i++) begin
      sdr_rd_valid = 1'b1;
      sdr_rd_data  = 16'h2018 + 16'(i);
      frame_start  = (i == 2) || (i == 4);
      @(negedge clk);
    end
    sdr_rd_valid = 1'b0; frame_start = 1'b0;
    wait_req(ok);
    if (!ok) return;
    checks++; if (sdr_rd_addr !== RESTART_BASE) begin fails++; $display("FAIL rs_newaddr got %h want %h", sdr_rd_addr, RESTART_BASE); end
    checks++; if (n_aclr !== 1) begin fails++; $display("FAIL rs_aclr_count got %0d want 1", n_aclr); end
    checks++; if (wq.size() !== 27) begin fails++; $display("FAIL rs_wcount got %0d want 27", wq.size()); end
    if (wq.size() >= 27) begin
      checks++; if (wq[26] !== 16'h201A) begin fails++; $display("FAIL rs_lastdata got %h want 201a", wq[26]); end
    end
    checks++; if (n_done !== 0) begin fails++; $display("FAIL rs_done got %0d want 0", n_done); end
  endtask

  task automatic test_dbuf();
    bit ok;
    logic [21:0] exp [3];
    exp[0] = B0; exp[1] = F2_BASE; exp[2] = B0;
    do_reset();
    for (int f = 0; f < 3; f++) begin
      fifo_usedw = '0;
      pulse_fs();
      wait_req(ok);
      if (!ok) return;
      checks++; if (sdr_rd_addr !== exp[f]) begin fails++; $display("FAIL dbuf_base frame %0d got %h want %h", f, sdr_rd_addr, exp[f]); end
      fifo_usedw = FAW'(2**FAW - 2*BURST + 1);
      ack_and_feed(16'h4000, BURST);
      cyc(2);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int sz;
    bit seen;
    do_reset();
    pulse_fs();
    wait_req(ok);
    if (!ok) return;
    sdr_rd_ack = 1'b1;
    @(negedge clk);
    sdr_rd_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sdr_rd_valid = 1'b1; sdr_rd_data = 16'h3000 + 16'(i);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checks++; if (fifo_wrreq !== 1'b0) begin fails++; $display("FAIL rm_wrreq got %b want 0", fifo_wrreq); end
    checks++; if (fifo_wrdata !== 16'h0) begin fails++; $display("FAIL rm_wrdata got %h want 0000", fifo_wrdata); end
    checks++; if (sdr_rd_req !== 1'b0) begin fails++; $display("FAIL rm_req got %b want 0", sdr_rd_req); end
    checks++; if (sdr_rd_addr !== B0) begin fails++; $display("FAIL rm_addr got %h want %h", sdr_rd_addr, B0); end
    checks++; if (fifo_aclr !== 1'b0) begin fails++; $display("FAIL rm_aclr got %b want 0", fifo_aclr); end
    checks++; if (frame_done !== 1'b0) begin fails++; $display("FAIL rm_done got %b want 0", frame_done); end
    @(negedge clk);
    rst = 1'b0;
    sz = wq.size();
    seen = 1'b0;
    for (int i = 0; i < BURST; i++) begin
      sdr_rd_valid = 1'b1; sdr_rd_data = 16'h3100 + 16'(i);
      seen |= sdr_rd_req;
      @(negedge clk);
    end
    sdr_rd_valid = 1'b0;
    cyc(3);
    checks++; if (wq.size() !== sz) begin fails++; $display("FAIL rm_ignored_writes got %0d want %0d", wq.size(), sz); end
    checks++; if (seen !== 1'b0) begin fails++; $display("FAIL rm_idle_req seen %b want 0", seen); end
  endtask

  initial begin
    rst = 1'b1;
    frame_start = 1'b0; fifo_usedw = '0; sdr_rd_ack = 1'b0;
    sdr_rd_valid = 1'b0; sdr_rd_data = '0;
    n_aclr = 0; n_done = 0; done_at = -1; bad_done = 0;
    test_reset();
    test_full_frame();
    test_threshold_ackdelay();
    test_restart();
    test_dbuf();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
